bus_server_memory: RTL and testbench

//  - Server-side responder of the 4-client bus arbiter. Receives the arbitrated

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_lfsr8.sv | 20 ++
 rtl/bus_server_memory.sv | 131 +++++++++++++
 tb/tb_bus_server_memory.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the arbiter's server-side responder: FSM state
// encoding, read/write polarity of server_wr_ni, and default bus widths.
package bus_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/bus_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1. Loads the seed on
// reset and steps once per cycle in which advance is high.
module bus_lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] value
);

    // Shift left, feeding back the XOR of the tap bits into bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= seed;
        end else if (advance) begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/bus_server_memory.sv
// Server-side memory responder behind the 4-client bus arbiter.
// 4-phase rq/ack handshake, programmable wait states, abort detection
// (proto_err) and a wrapping served-transaction counter.
// Optional feature macro: BUS_SERVER_RAND_LAT_EN -- when defined, the
// wait count per transaction is drawn from an LFSR (lfsr % (LATENCY+1)).
//
// state | meaning
// IDLE  | waiting for rq; captures address/direction/data on rq
// WAIT  | counting down wait states; abort if rq drops
// ACK   | access done, ack held until rq drops
module bus_server_memory
    import bus_arb_pkg::*;
#(
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int         LATENCY    = 2,
    parameter int         CNT_WIDTH  = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] server_address,
    input  logic                  server_rq,
    input  logic                  server_wr_ni,
    input  logic [DATA_WIDTH-1:0] server_dataW,
    output logic                  server_ack,
    output logic [DATA_WIDTH-1:0] server_dataR,
    output logic                  busy,
    output logic                  proto_err,
    output logic [CNT_WIDTH-1:0]  served_cnt
);

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_load;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_wr_ni;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  access;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // The access fires on the last WAIT edge, provided rq is still held.
    assign access = (state == WAIT) && server_rq && (wait_cnt == 4'd0);

`ifdef BUS_SERVER_RAND_LAT_EN
    logic [7:0] lfsr_value;
    logic       lfsr_advance;

    // The LFSR steps exactly once per accepted request, after its value is used.
    assign lfsr_advance = (state == IDLE) && server_rq;

    bus_lfsr8 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (LFSR_SEED),
        .advance (lfsr_advance),
        .value   (lfsr_value)
    );

    assign wait_load = 4'(lfsr_value % 8'(LATENCY + 1));
`else
    assign wait_load = 4'(LATENCY);
`endif

    // Memory array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (access && (cap_wr_ni == RW_WRITE)) begin
            mem[cap_addr] <= cap_data;
        end
    end

    // Handshake FSM with capture registers, read data, error pulse and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            cap_addr     <= '0;
            cap_wr_ni    <= RW_READ;
            cap_data     <= '0;
            server_ack   <= 1'b0;
            server_dataR <= '0;
            busy         <= 1'b0;
            proto_err    <= 1'b0;
            served_cnt   <= '0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (server_rq) begin
                        cap_addr  <= server_address;
                        cap_wr_ni <= server_wr_ni;
                        cap_data  <= server_dataW;
                        wait_cnt  <= wait_load;
                        state     <= WAIT;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!server_rq) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (cap_wr_ni == RW_READ) begin
                            server_dataR <= mem[cap_addr];
                        end
                        server_ack <= 1'b1;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    if (!server_rq) begin
                        server_ack <= 1'b0;
                        served_cnt <= served_cnt + 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    server_ack <= 1'b0;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_server_memory.sv
// Scoreboard bench for bus_server_memory (DATA 8, ADDR 4, LATENCY 2, CNT 8).
// Driver pushes the expected response per request; a negedge monitor pops
// on each ack rise and checks latency and read data, and checks served_cnt
// on each completion.
module tb_bus_server_memory;

    localparam int LAT = 2;

    logic       clk;
    logic       rst;
    logic [3:0] server_address;
    logic       server_rq;
    logic       server_wr_ni;
    logic [7:0] server_dataW;
    logic       server_ack;
    logic [7:0] server_dataR;
    logic       busy;
    logic       proto_err;
    logic [7:0] served_cnt;

    bus_server_memory #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .LATENCY    (LAT),
        .CNT_WIDTH  (8),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk            (clk),
        .reset          (rst),
        .server_address (server_address),
        .server_rq      (server_rq),
        .server_wr_ni   (server_wr_ni),
        .server_dataW   (server_dataW),
        .server_ack     (server_ack),
        .server_dataR   (server_dataR),
        .busy           (busy),
        .proto_err      (proto_err),
        .served_cnt     (served_cnt)
    );

    typedef struct {
        logic       is_read;
        logic [7:0] data;
        int         start;
    } sb_item_t;

    sb_item_t   sb[$];
    logic [7:0] mem_m [16];
    logic       written [16];
    int         total = 0;
    int         bad   = 0;
    int         cycle = 0;
    logic [7:0] exp_served = 8'd0;
    logic [7:0] last_read  = 8'd0;
    logic       prev_ack   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT responses against the scoreboard at negedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_served = 8'd0;
            last_read  = 8'd0;
            prev_ack   = 1'b0;
        end else begin
            if (server_ack && proto_err) check("ack_and_proto_err", 1, 0);
            if (server_ack && !prev_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    sb_item_t it;
                    int       lat;
                    it  = sb.pop_front();
                    lat = cycle - it.start;
`ifdef BUS_SERVER_RAND_LAT_EN
                    check("latency_in_range", (lat >= 1 && lat <= LAT + 1) ? 1 : 0, 1);
`else
                    check("latency", lat, LAT + 1);
`endif
                    if (it.is_read) begin
                        check("read_data", server_dataR, it.data);
                        last_read = it.data;
                    end else begin
                        check("dataR_hold", server_dataR, last_read);
                    end
                end
            end
            if (!server_ack && prev_ack) begin
                exp_served = exp_served + 8'd1;
                check("served_cnt", served_cnt, exp_served);
            end
            prev_ack = server_ack;
        end
    end

    // One complete handshake; returns at the negedge after ack has fallen,
    // so a following call re-raises rq in the cycle after ack falls.
    task automatic txn(input logic rd, input logic [3:0] a, input logic [7:0] d);
        sb_item_t it;
        int       n;
        it.is_read = rd;
        it.data    = rd ? mem_m[a] : d;
        it.start   = cycle + 1;
        if (!rd) begin
            mem_m[a]   = d;
            written[a] = 1'b1;
        end
        sb.push_back(it);
        server_address = a;
        server_wr_ni   = rd;
        server_dataW   = d;
        server_rq      = 1'b1;
        @(negedge clk);
        // Captured values must be used; disturb the inputs after capture.
        server_address = 4'($urandom);
        server_dataW   = 8'($urandom);
        server_wr_ni   = ~rd;
        n = 0;
        while (!server_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!server_ack) begin
            check("ack_timeout", 0, 1);
            void'(sb.pop_back());
        end
        server_rq = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        server_rq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] snap;
        int         n;
        for (int i = 0; i < 16; i++) begin
            mem_m[i]   = 8'h00;
            written[i] = 1'b0;
        end
        rst            = 1'b1;
        server_rq      = 1'b0;
        server_address = 4'h0;
        server_wr_ni   = 1'b1;
        server_dataW   = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ack", server_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_served", served_cnt, 0);
        check("rst_dataR", server_dataR, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Basic write then read back.
        txn(1'b0, 4'h3, 8'hA5);
        txn(1'b1, 4'h3, 8'h00);
        check("served_after_two", served_cnt, 2);

        // Address extremes.
        txn(1'b0, 4'hF, 8'hFF);
        txn(1'b0, 4'h0, 8'h00);
        txn(1'b1, 4'hF, 8'h00);
        txn(1'b1, 4'h0, 8'h00);

        // Abort after one WAIT cycle.
        snap           = served_cnt;
        server_address = 4'h3;
        server_wr_ni   = 1'b1;
        server_rq      = 1'b1;
        @(negedge clk);
        check("abort_busy_wait", busy, 1);
        @(negedge clk);
        server_rq = 1'b0;
        @(negedge clk);
        check("abort_proto_err", proto_err, 1);
        check("abort_no_ack", server_ack, 0);
        @(negedge clk);
        check("abort_pulse_len", proto_err, 0);
        check("abort_busy_idle", busy, 0);
        check("abort_served", served_cnt, snap);

        // Reset in the middle of ACK.
        sb.push_back('{is_read: 1'b1, data: mem_m[3], start: cycle + 1});
        server_address = 4'h3;
        server_wr_ni   = 1'b1;
        server_rq      = 1'b1;
        n = 0;
        while (!server_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_ack_reached", server_ack, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ack", server_ack, 0);
        check("midrst_busy", busy, 0);
        check("midrst_served", served_cnt, 0);
        server_rq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        txn(1'b1, 4'h3, 8'h00);

        // Randomised mix against the reference memory.
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            if (($urandom & 1) != 0 && written[a]) txn(1'b1, a, 8'h00);
            else txn(1'b0, a, 8'($urandom));
        end

        // Back-to-back writes until the counter wraps.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            txn(1'b0, 4'(i), 8'(i * 7 + 1));
        end
        check("wrap_served", served_cnt, 0);
        for (int i = 0; i < 16; i++) txn(1'b1, 4'(i), 8'h00);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
